// File: rtl/fifo_arb_defs_pkg.sv
// Shared definitions for the FIFO write arbiter.
//   arb_state_e : arbiter FSM state encoding (ST_IDLE = 0, ST_BURST = 1)
//   STAT_W      : width of the optional per-requester accepted-word counters
//   clog2()     : index width helper, never returns less than 1
package fifo_arb_defs;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_e;

    localparam int unsigned STAT_W = 16;

    // Bits needed to index 'value' items; at least 1 so single-item vectors stay legal.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((64'd1 << result) < 64'(value)) begin
            result++;
        end
        return (result == 0) ? 1 : result;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req    in   NREQ  request vector
//   rr_ptr in   IW    highest-priority index; search runs rr_ptr, rr_ptr+1, ... mod NREQ
//   idx    out  IW    first requesting index found (0 when none)
//   found  out  1     at least one request is set
module rr_pick
    import fifo_arb_defs::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IW   = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   rr_ptr,
    output logic [IW-1:0]   idx,
    output logic            found
);

    int unsigned    cand;
    logic [IW-1:0]  cand_idx;

    always_comb begin
        idx      = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand     = (32'(rr_ptr) + k) % NREQ;
            cand_idx = cand[IW-1:0];
            if (!found && req[cand_idx]) begin
                idx   = cand_idx;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one FIFO write port among NREQ requesters.
// A requester wins a burst of up to MAX_BURST words; every burst is followed by one
// IDLE cycle in which the next owner is picked starting after the previous owner.
// Optional feature macro: FIFO_ARB_STATS_EN adds per-requester accepted-word counters.
// Ports:
//   clk       in   1            write clock (FIFO clk_in)
//   arst      in   1            asynchronous reset, active-high
//   req       in   NREQ         requester i has a valid word on its req_data slice
//   req_data  in   NREQ*N       flattened requester data, slice i = [i*N +: N]
//   gnt       out  NREQ         one-hot, word of requester i accepted this cycle
//   full      in   1            FIFO full
//   w_en      out  1            FIFO write enable (= |gnt)
//   data_in   out  N            FIFO write data (owner's slice while busy, else 0)
//   busy      out  1            burst in progress
//   owner     out  clog2(NREQ)  current / last burst owner
//   stat_clr  in   1            (FIFO_ARB_STATS_EN) synchronous counter clear
//   stat_cnt  out  NREQ*16      (FIFO_ARB_STATS_EN) accepted-word counts, slice i per requester
module fifo_wr_arbiter
    import fifo_arb_defs::*;
#(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned N         = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                      clk,
    input  logic                      arst,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*N-1:0]         req_data,
    output logic [NREQ-1:0]           gnt,
    input  logic                      full,
    output logic                      w_en,
    output logic [N-1:0]              data_in,
    output logic                      busy,
    output logic [clog2(NREQ)-1:0]    owner
`ifdef FIFO_ARB_STATS_EN
    ,
    input  logic                      stat_clr,
    output logic [NREQ*STAT_W-1:0]    stat_cnt
`endif
);

    localparam int unsigned OW = clog2(NREQ);
    localparam int unsigned BW = clog2(MAX_BURST);
    localparam logic [OW-1:0] LAST_REQ  = OW'(NREQ - 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);

    arb_state_e     state_q, state_d;
    logic [OW-1:0]  owner_q, owner_d;
    logic [OW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [BW-1:0]  beat_q, beat_d;
    logic [OW-1:0]  pick_idx;
    logic           pick_found;
    logic [OW-1:0]  owner_inc;
    logic           owner_req;
    logic           accept;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (OW)
    ) u_rr_pick (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .idx    (pick_idx),
        .found  (pick_found)
    );

    // Explicit wrap so non-power-of-2 NREQ works.
    assign owner_inc = (owner_q == LAST_REQ) ? '0 : owner_q + OW'(1);
    assign owner_req = req[owner_q];
    assign busy      = (state_q == ST_BURST);
    assign accept    = busy & owner_req & ~full;
    assign w_en      = accept;
    assign owner     = owner_q;

    always_comb begin
        gnt          = '0;
        gnt[owner_q] = accept;
    end

    always_comb begin
        data_in = '0;
        if (busy) begin
            data_in = req_data[owner_q * N +: N];
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        beat_d   = beat_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    owner_d = pick_idx;
                    beat_d  = '0;
                    state_d = ST_BURST;
                end
            end
            ST_BURST: begin
                if (!owner_req) begin
                    // Owner ran dry: end the burst early, nothing granted this cycle.
                    state_d  = ST_IDLE;
                    rr_ptr_d = owner_inc;
                end else if (!full) begin
                    if (beat_q == LAST_BEAT) begin
                        state_d  = ST_IDLE;
                        rr_ptr_d = owner_inc;
                    end else begin
                        beat_d = beat_q + BW'(1);
                    end
                end
                // req & full: stall with beat count held.
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q  <= ST_IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            beat_q   <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            beat_q   <= beat_d;
        end
    end

`ifdef FIFO_ARB_STATS_EN
    logic [STAT_W-1:0] stat_q [NREQ];

    // Clear takes priority over a same-cycle grant; counters wrap naturally.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                stat_q[i] <= '0;
            end
        end else if (stat_clr) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                stat_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (gnt[i]) begin
                    stat_q[i] <= stat_q[i] + STAT_W'(1);
                end
            end
        end
    end

    always_comb begin
        stat_cnt = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            stat_cnt[i*STAT_W +: STAT_W] = stat_q[i];
        end
    end
`else
    // Statistics counters not built.
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: per-requester source queues drive req/req_data, the
// expected FIFO write stream is pushed into a scoreboard by each test, and a monitor
// pops and compares on every w_en.
module tb_fifo_wr_arbiter;

    localparam int NREQ = 4;
    localparam int N    = 8;
    localparam int MB   = 4;

    logic              clk = 1'b0;
    logic              arst;
    logic [NREQ-1:0]   req;
    logic [NREQ*N-1:0] req_data;
    logic [NREQ-1:0]   gnt;
    logic              full;
    logic              w_en;
    logic [N-1:0]      data_in;
    logic              busy;
    logic [1:0]        owner;
`ifdef FIFO_ARB_STATS_EN
    logic              stat_clr;
    logic [NREQ*16-1:0] stat_cnt;
`endif

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .NREQ      (NREQ),
        .N         (N),
        .MAX_BURST (MB)
    ) dut (
        .clk      (clk),
        .arst     (arst),
        .req      (req),
        .req_data (req_data),
        .gnt      (gnt),
        .full     (full),
        .w_en     (w_en),
        .data_in  (data_in),
        .busy     (busy),
        .owner    (owner)
`ifdef FIFO_ARB_STATS_EN
        ,
        .stat_clr (stat_clr),
        .stat_cnt (stat_cnt)
`endif
    );

    typedef struct {
        int         who;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         acc_cyc[$];
    logic [7:0] src[NREQ][$];
    int         n_chk  = 0;
    int         n_pass = 0;
    int         ncyc   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_chk++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got 'h%0h, required 'h%0h", name, act, want);
    endtask

    // Monitor: scoreboard pop on every FIFO write.
    always @(negedge clk) begin
        ncyc++;
        if (arst === 1'b0) begin
            chk("w_en_is_or_gnt", w_en, |gnt);
            if (full) chk("no_write_while_full", w_en, 0);
            if (w_en) begin
                acc_cyc.push_back(ncyc);
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", exp_q.size(), 1);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("wr_data", data_in, mon_e.data);
                    chk("wr_owner", owner, mon_e.who);
                    chk("wr_gnt", gnt, 64'(1) << mon_e.who);
                end
            end
        end
    end

    task automatic drive_req();
        for (int i = 0; i < NREQ; i++) begin
            req[i] = (src[i].size() != 0);
            req_data[i*N +: N] = req[i] ? src[i][0] : 8'h00;
        end
    endtask

    // One clock: sample grants mid-cycle, consume granted words after the edge.
    task automatic tick();
        logic [NREQ-1:0] g;
        @(negedge clk);
        g = gnt;
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (g[i] && src[i].size() != 0) void'(src[i].pop_front());
        end
        drive_req();
    endtask

    task automatic load(input int who, input logic [7:0] first, input int count);
        for (int k = 0; k < count; k++) src[who].push_back(first + 8'(k));
    endtask

    task automatic push_exp(input int who, input logic [7:0] first, input int count);
        exp_t e;
        for (int k = 0; k < count; k++) begin
            e.who  = who;
            e.data = first + 8'(k);
            exp_q.push_back(e);
        end
    endtask

    task automatic run_until_done(input string name, input int budget);
        int k;
        bit pending;
        k = 0;
        pending = 1'b1;
        while (pending && k < budget) begin
            pending = (exp_q.size() != 0);
            for (int i = 0; i < NREQ; i++) if (src[i].size() != 0) pending = 1'b1;
            if (pending) begin
                tick();
                k++;
            end
        end
        repeat (2) tick();
        chk({name, "_drained"}, exp_q.size(), 0);
    endtask

    task automatic do_reset();
        arst = 1'b1;
        full = 1'b0;
        for (int i = 0; i < NREQ; i++) src[i].delete();
        exp_q.delete();
        drive_req();
        repeat (2) @(posedge clk);
        @(negedge clk);
        arst = 1'b0;
        tick();
    endtask

    task automatic check_gaps(input string name, input int t0, input int rel[$]);
        chk({name, "_count"}, acc_cyc.size(), rel.size());
        if (acc_cyc.size() == rel.size()) begin
            chk({name, "_first_gnt"}, acc_cyc[0] - t0, 2);
            for (int k = 1; k < rel.size(); k++) begin
                chk({name, "_gnt_cycle"}, acc_cyc[k] - acc_cyc[0], rel[k]);
            end
        end
    endtask

    int t0;

    initial begin
        arst     = 1'b1;
        full     = 1'b0;
        req      = '0;
        req_data = '0;
`ifdef FIFO_ARB_STATS_EN
        stat_clr = 1'b0;
`endif

        // Test 1: reset held with all requesters active.
        for (int i = 0; i < NREQ; i++) load(i, 8'(8'h10 * i), 1);
        drive_req();
        repeat (4) begin
            @(negedge clk);
            chk("rst_gnt", gnt, 0);
            chk("rst_w_en", w_en, 0);
            chk("rst_busy", busy, 0);
            chk("rst_owner", owner, 0);
            chk("rst_data_in", data_in, 0);
        end
        do_reset();

        // Test 2: single requester 2, six words -> bursts of 4 then 2.
        load(2, 8'hA0, 6);
        push_exp(2, 8'hA0, 6);
        acc_cyc.delete();
        t0 = ncyc;
        drive_req();
        run_until_done("single", 60);
        check_gaps("single", t0, '{0, 1, 2, 3, 5, 6});

        // Test 3: all requesting, two full rounds, owners rotate 0,1,2,3,0,1,2,3.
        do_reset();
        for (int i = 0; i < NREQ; i++) load(i, 8'(8'h10 * i), 8);
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < NREQ; i++) push_exp(i, 8'(8'h10 * i + 4 * r), 4);
        end
        drive_req();
        run_until_done("all_rr", 120);
`ifdef FIFO_ARB_STATS_EN
        for (int i = 0; i < NREQ; i++) chk("stat_cnt_rounds", stat_cnt[i*16 +: 16], 8);
        @(negedge clk);
        stat_clr = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0;
        for (int i = 0; i < NREQ; i++) chk("stat_cnt_clr", stat_cnt[i*16 +: 16], 0);
`endif

        // Test 4: full for three cycles after two words; beat count must freeze.
        do_reset();
        load(1, 8'h30, 8);
        push_exp(1, 8'h30, 8);
        acc_cyc.delete();
        t0 = ncyc;
        drive_req();
        repeat (3) tick();
        full = 1'b1;
        repeat (3) begin
            tick();
            chk("stall_busy", busy, 1);
            chk("stall_owner", owner, 1);
        end
        full = 1'b0;
        run_until_done("stall", 60);
        check_gaps("stall", t0, '{0, 1, 5, 6, 8, 9, 10, 11});

        // Test 5: owner 0 runs dry after two words, owner 1 takes over.
        do_reset();
        load(0, 8'h50, 2);
        load(1, 8'h60, 3);
        push_exp(0, 8'h50, 2);
        push_exp(1, 8'h60, 3);
        acc_cyc.delete();
        t0 = ncyc;
        drive_req();
        run_until_done("early_end", 60);
        check_gaps("early_end", t0, '{0, 1, 4, 5, 6});

        // Test 6: reset in the middle of a burst by requester 3.
        do_reset();
        load(3, 8'hC0, 4);
        push_exp(3, 8'hC0, 4);
        drive_req();
        repeat (3) tick();
        chk("pre_rst_busy", busy, 1);
        chk("pre_rst_owner", owner, 3);
        arst = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_owner", owner, 0);
        chk("mid_rst_w_en", w_en, 0);
        chk("mid_rst_gnt", gnt, 0);
        chk("mid_rst_data_in", data_in, 0);
        do_reset();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed",
                 n_pass, n_chk);
        $fatal(1, "watchdog");
    end

endmodule
